pio_hps_responder: RTL
======================

Name: pio_hps_responder

Overview:
- Avalon-MM responder (slave) on the HPS lightweight bridge; the FPGA-side end of the HEX/LED/KEY PIO exports.
- HPS software writes raw seven-segment patterns and LED bits, and reads debounced key state.
- Key press edges are captured into a register; a maskable level interrupt goes to the HPS.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive stable clk cycles a synchronized key sample must hold before it is accepted; legal range is 2 or more.
- NUM_KEYS, 4, number of pushbutton inputs.
- NUM_LEDS, 10, number of LED outputs.

Ports:
- clk_clk  in  1  single system clock.
- reset_reset  in  1  asynchronous, active-high reset.
- avs_address  in  3  word address.
- avs_read  in  1  read strobe.
- avs_write  in  1  write strobe.
- avs_writedata  in  32  write data.
- avs_byteenable  in  4  byte lanes for the write.
- avs_readdata  out  32  read data, valid 1 cycle after avs_read.
- irq  out  1  level interrupt to the HPS.
- keys_export  in  NUM_KEYS  raw pushbuttons; asynchronous, active-low.
- hex30_export  out  32  HEX3..HEX0 segment bytes; active-low segments.
- hex54_export  out  16  HEX5..HEX4 segment bytes.
- leds_export  out  NUM_LEDS  LED drive; active-high.

Behaviour:
- Reset (async assert; all registers cleared regardless of bus activity in progress):
  - hex30_export = 32'hFFFF_FFFF, hex54_export = 16'hFFFF (all segments off).
  - leds_export = 0, mask = 0, edge = 0, avs_readdata = 0, irq = 0.
  - Debounced pressed state = 0; synchronizers and counters = 0.
- Register map (word address), bits above each width read 0:
  - 0 HEX30, RW, 32 bits.
  - 1 HEX54, RW, 16 bits.
  - 2 KEYS, RO, NUM_KEYS bits; debounced pressed state, 1 = pressed.
  - 3 MASK, RW, NUM_KEYS bits.
  - 4 EDGE, RW1C, NUM_KEYS bits.
  - 5 LEDS, RW, NUM_LEDS bits.
  - 6 and 7 unmapped: read 0; writes ignored.
- Bus protocol:
  - No waitrequest; every access completes.
  - Fixed read latency 1: avs_readdata is registered in the avs_read cycle and holds its value while avs_read is low.
  - Writes take effect on the clock edge of the avs_write cycle; only lanes with byteenable=1 update (addresses 0, 1, 3, 5).
  - EDGE clears bit i when lane 0 is enabled and writedata[i]=1.
  - Simultaneous read and write to the same address: the read returns the old value.
- Key path, per key, implemented as key_debounce:
  - Invert raw input, then a 2-flop synchronizer gives sample s.
  - Counter counts while s differs from the stable state; any cycle with s equal to the stable state clears the counter.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, the stable state takes s and the counter clears.
  - Latency from a raw edge to the KEYS bit: 2 + DEBOUNCE_CYCLES cycles. Glitches shorter than DEBOUNCE_CYCLES never propagate.
  - Counter width = clog2(DEBOUNCE_CYCLES); no wrap is possible.
- Edge capture:
  - A stable-state transition 0->1 (press) sets EDGE[i]; release sets nothing.
  - A press event in the same cycle as a W1C to that bit: set wins, and the bit stays 1.
  - Repeated presses leave the bit 1 (sticky, no count).
- irq is registered: irq = |(EDGE & MASK), delayed by 1 cycle from the register update.
  - A MASK write or EDGE clear deasserts irq on the following cycle.

Decomposition:
- Package pio_hps_pkg:
  - Register address constants: ADDR_HEX30..ADDR_LEDS.
  - Reset constants: HEX_OFF32, HEX_OFF16.
  - Avalon data width constant (32).
- One sub-module, key_debounce: synchronizer, counter and stable-state register for a single key, with a press pulse output. Instantiated NUM_KEYS times.
- Top holds the register file, read mux, edge/irq logic.

Test Plan:
- Reset and write path: assert reset_reset mid-write -> all outputs at reset values. Then write addr 0 data 32'h1234_5678 with be=4'b0101 -> hex30_export = 32'hFF34_FF78. A read of addr 0 returns the same one cycle later.
- Debounce with DEBOUNCE_CYCLES=4: hold keys_export[1]=0 for 6 cycles -> KEYS bit1=1 exactly 6 cycles after the edge. Then a 3-cycle low glitch on key 2 -> KEYS bit2 stays 0 and EDGE stays 0.
- Interrupt: MASK=4'b0010, press key1 -> EDGE=4'b0010 and irq=1 one cycle later. Write EDGE 4'b0010 -> EDGE=0 and irq=0 next cycle.
- Collision: schedule a W1C of EDGE bit0 in the exact cycle key0's press is accepted -> EDGE bit0 remains 1.
- Unmapped/width: write 32'hFFFF_FFFF to addr 5 and addr 6 -> leds_export=10'h3FF; reads of addr 6 and addr 7 return 0; addr 5 reads 32'h0000_03FF.
- Key release: release a pressed key -> KEYS bit clears after 2+DEBOUNCE_CYCLES cycles; EDGE and irq unchanged.

Source files
------------

// File: rtl/pio_hps_pkg.sv
// Shared constants and helpers for the HPS PIO responder: register map,
// reset patterns and the Avalon byte-lane merge.
package pio_hps_pkg;

  localparam int AVS_DATA_W = 32;
  localparam int AVS_BE_W   = AVS_DATA_W / 8;

  typedef enum logic [2:0] {
    ADDR_HEX30 = 3'd0,
    ADDR_HEX54 = 3'd1,
    ADDR_KEYS  = 3'd2,
    ADDR_MASK  = 3'd3,
    ADDR_EDGE  = 3'd4,
    ADDR_LEDS  = 3'd5
  } reg_addr_e;

  // Seven-segment outputs are active-low, so all ones blanks the display.
  localparam logic [31:0] HEX_OFF32 = 32'hFFFF_FFFF;
  localparam logic [15:0] HEX_OFF16 = 16'hFFFF;

  function automatic logic [AVS_DATA_W-1:0] be_merge(
    input logic [AVS_DATA_W-1:0] old_val,
    input logic [AVS_DATA_W-1:0] wdata,
    input logic [AVS_BE_W-1:0]   be
  );
    logic [AVS_DATA_W-1:0] res;
    res = old_val;
    for (int b = 0; b < AVS_BE_W; b++) begin
      if (be[b]) res[8*b +: 8] = wdata[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/pio_hps_responder_if.sv
// Avalon-MM slave bus from the HPS lightweight bridge (no waitrequest,
// fixed read latency of one cycle).
interface pio_hps_responder_if;
    import pio_hps_pkg::*;

    logic [2:0]            avs_address;
    logic                  avs_read;
    logic                  avs_write;
    logic [AVS_DATA_W-1:0] avs_writedata;
    logic [AVS_BE_W-1:0]   avs_byteenable;
    logic [AVS_DATA_W-1:0] avs_readdata;

    modport master (
        output avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
        input  avs_readdata
    );

    modport slave (
        input  avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
        output avs_readdata
    );

endinterface

// File: rtl/key_debounce.sv
// One pushbutton: invert, 2-flop synchronize, then accept a new level only
// after it has been seen for DEBOUNCE_CYCLES consecutive cycles.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic pressed,
    output logic press
);

    localparam int             CW       = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    // High for the single cycle in which a press is about to be accepted.
    assign press = sync2 & ~pressed & (cnt == CNT_LAST);

    // NOTE: every flop here uses <= so all of them sample pre-edge values;
    // a blocking assignment would collapse the synchronizer into one stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            cnt     <= '0;
            pressed <= 1'b0;
        end else begin
            sync1 <= ~key_n;
            sync2 <= sync1;
            if (sync2 == pressed) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                pressed <= sync2;
                cnt     <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/pio_hps_responder.sv
// FPGA-side end of the HEX/LED/KEY PIO exports: register file, read mux,
// sticky press-edge capture and a maskable level interrupt.
module pio_hps_responder
    import pio_hps_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int NUM_KEYS        = 4,
    parameter int NUM_LEDS        = 10
) (
    input  logic                 clk_clk,
    input  logic                 reset_reset,
    pio_hps_responder_if.slave   avs,
    output logic                 irq,
    input  logic [NUM_KEYS-1:0]  keys_export,
    output logic [31:0]          hex30_export,
    output logic [15:0]          hex54_export,
    output logic [NUM_LEDS-1:0]  leds_export
);

    logic [NUM_KEYS-1:0]   keys_q;
    logic [NUM_KEYS-1:0]   press;
    logic [NUM_KEYS-1:0]   mask_q;
    logic [NUM_KEYS-1:0]   edge_q;
    logic [NUM_KEYS-1:0]   edge_clr;
    logic [AVS_DATA_W-1:0] rd_data;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk     (clk_clk),
            .rst     (reset_reset),
            .key_n   (keys_export[i]),
            .pressed (keys_q[i]),
            .press   (press[i])
        );
    end

    // NOTE: each always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        edge_clr = '0;
        if (avs.avs_write && avs.avs_address == ADDR_EDGE && avs.avs_byteenable[0])
            edge_clr = avs.avs_writedata[NUM_KEYS-1:0];
    end

    always_comb begin
        rd_data = '0;
        case (avs.avs_address)
            ADDR_HEX30: rd_data = hex30_export;
            ADDR_HEX54: rd_data = AVS_DATA_W'(hex54_export);
            ADDR_KEYS:  rd_data = AVS_DATA_W'(keys_q);
            ADDR_MASK:  rd_data = AVS_DATA_W'(mask_q);
            ADDR_EDGE:  rd_data = AVS_DATA_W'(edge_q);
            ADDR_LEDS:  rd_data = AVS_DATA_W'(leds_export);
            default:    rd_data = '0;
        endcase
    end

    // NOTE: reset is asynchronous and clears every register, including the
    // read data holding register, regardless of a bus access in flight.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            hex30_export     <= HEX_OFF32;
            hex54_export     <= HEX_OFF16;
            leds_export      <= '0;
            mask_q           <= '0;
            edge_q           <= '0;
            irq              <= 1'b0;
            avs.avs_readdata <= '0;
        end else begin
            if (avs.avs_write) begin
                case (avs.avs_address)
                    ADDR_HEX30: hex30_export <= be_merge(hex30_export,
                                    avs.avs_writedata, avs.avs_byteenable);
                    ADDR_HEX54: hex54_export <= 16'(be_merge(AVS_DATA_W'(hex54_export),
                                    avs.avs_writedata, avs.avs_byteenable));
                    ADDR_MASK:  mask_q <= NUM_KEYS'(be_merge(AVS_DATA_W'(mask_q),
                                    avs.avs_writedata, avs.avs_byteenable));
                    ADDR_LEDS:  leds_export <= NUM_LEDS'(be_merge(AVS_DATA_W'(leds_export),
                                    avs.avs_writedata, avs.avs_byteenable));
                    default: ;
                endcase
            end

            // A press arriving with a W1C of the same bit keeps the bit set.
            edge_q <= (edge_q & ~edge_clr) | press;
            irq    <= |(edge_q & mask_q);

            if (avs.avs_read) avs.avs_readdata <= rd_data;
        end
    end

endmodule
